// File: rtl/mips_pkg.sv
// Shared MIPS32 constants: bubble word, instruction field bit positions, PC defaults.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mips_pkg;

  localparam int          PC_W_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // sll $0,$0,0 encodes as all zeros
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  // Instruction field bit positions
  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int JIDX_HI  = 25;
  localparam int JIDX_LO  = 0;

endpackage

// File: rtl/if_id_stage.sv
// Instruction fetch (PC register, imem address) plus IF/ID pipeline register with decode field split.
// Latency: fetched word appears on id_instr one cycle after its PC is on imem_addr; decode fields add none.
// Backpressure: stall freezes PC and IF/ID; redirect overrides stall on the PC; flush bubbles IF/ID.
//
// Optional macro BRANCH_DELAY_SLOT_EN: when defined, the instruction fetched alongside a redirect
// (the delay slot) is kept in IF/ID; when undefined it is squashed into a bubble.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   imem_addr / imem_rdata          instruction memory address (=PC) and same-cycle read data
//   stall, redirect, redirect_pc    hazard hold and branch/jump target from ID
//   flush                           kill IF/ID contents
//   id_valid, id_instr, id_pc_plus4 IF/ID register contents
//   id_opcode .. id_imm16           combinational field slices of id_instr
//   id_jtarget                      J-type target {pc_plus4[31:28], instr_index, 2'b00}
module if_id_stage
  import mips_pkg::*;
#(
  parameter int               PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0]  RESET_PC  = PC_W'(RESET_PC_DEF),
  parameter logic [31:0]      NOP_INSTR = MIPS_NOP
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            flush,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [PC_W-1:0] id_pc_plus4,
  output logic [5:0]      id_opcode,
  output logic [4:0]      id_rs,
  output logic [4:0]      id_rt,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_shamt,
  output logic [5:0]      id_funct,
  output logic [15:0]     id_imm16,
  output logic [PC_W-1:0] id_jtarget
);

  logic [PC_W-1:0] r_pc;
  logic            r_id_valid;
  logic [31:0]     r_id_instr;
  logic [PC_W-1:0] r_id_pc_plus4;
  logic [PC_W-1:0] w_pc_plus4;

  // Unsigned add wraps naturally modulo 2^PC_W
  assign w_pc_plus4 = r_pc + PC_W'(4);

  // PC: redirect beats stall so a resolved branch is never dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (redirect) begin
      r_pc <= redirect_pc;
    end else if (!stall) begin
      r_pc <= w_pc_plus4;
    end
  end

  // IF/ID register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_valid    <= 1'b0;
      r_id_instr    <= NOP_INSTR;
      r_id_pc_plus4 <= '0;
    end else if (flush) begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
    end else if (redirect) begin
`ifdef BRANCH_DELAY_SLOT_EN
      // Delay slot executes; a coincident stall still holds it in place
      if (!stall) begin
        r_id_valid    <= 1'b1;
        r_id_instr    <= imem_rdata;
        r_id_pc_plus4 <= w_pc_plus4;
      end
`else
      // Wrong-path word fetched alongside the redirect is squashed
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
`endif
    end else if (!stall) begin
      r_id_valid    <= 1'b1;
      r_id_instr    <= imem_rdata;
      r_id_pc_plus4 <= w_pc_plus4;
    end
  end

  assign imem_addr   = r_pc;
  assign id_valid    = r_id_valid;
  assign id_instr    = r_id_instr;
  assign id_pc_plus4 = r_id_pc_plus4;

  assign id_opcode  = r_id_instr[OPC_HI:OPC_LO];
  assign id_rs      = r_id_instr[RS_HI:RS_LO];
  assign id_rt      = r_id_instr[RT_HI:RT_LO];
  assign id_rd      = r_id_instr[RD_HI:RD_LO];
  assign id_shamt   = r_id_instr[SHAMT_HI:SHAMT_LO];
  assign id_funct   = r_id_instr[FUNCT_HI:FUNCT_LO];
  assign id_imm16   = r_id_instr[IMM_HI:IMM_LO];
  assign id_jtarget = {r_id_pc_plus4[PC_W-1:28], r_id_instr[JIDX_HI:JIDX_LO], 2'b00};

endmodule

// File: tb/tb_if_id_stage.sv
// Directed table-driven bench for if_id_stage: reset, sequential fetch, stall, redirect (with and
// without stall), flush, jump target, PC wrap, mid-operation reset, unaligned redirect.
// Expectations follow BRANCH_DELAY_SLOT_EN when the macro is defined for the build.
module tb_if_id_stage;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit BDS = 1'b1;
`else
  localparam bit BDS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_shamt;
  logic [5:0]  id_funct;
  logic [15:0] id_imm16;
  logic [31:0] id_jtarget;

  int total = 0;
  int bad   = 0;

  if_id_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc_plus4 (id_pc_plus4),
    .id_opcode   (id_opcode),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .id_shamt    (id_shamt),
    .id_funct    (id_funct),
    .id_imm16    (id_imm16),
    .id_jtarget  (id_jtarget)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        flush;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [31:0] e_pp4;
    logic        chk_pp4;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic rd, logic [31:0] rpc, logic f,
                              logic [31:0] dat, logic [31:0] ea, logic ev,
                              logic [31:0] ei, logic [31:0] ep, logic cp);
    vec_t v;
    v.rst = r; v.stall = s; v.redirect = rd; v.rpc = rpc; v.flush = f; v.rdata = dat;
    v.e_addr = ea; v.e_vld = ev; v.e_instr = ei; v.e_pp4 = ep; v.chk_pp4 = cp;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic s, logic rd, logic [31:0] rpc, logic f, logic [31:0] dat);
    @(negedge clk);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc; flush = f; imem_rdata = dat;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fields(string tag, logic [31:0] ei);
    chk({tag, ".opcode"}, 32'(id_opcode), 32'(ei[31:26]));
    chk({tag, ".rs"},     32'(id_rs),     32'(ei[25:21]));
    chk({tag, ".rt"},     32'(id_rt),     32'(ei[20:16]));
    chk({tag, ".rd"},     32'(id_rd),     32'(ei[15:11]));
    chk({tag, ".shamt"},  32'(id_shamt),  32'(ei[10:6]));
    chk({tag, ".funct"},  32'(id_funct),  32'(ei[5:0]));
    chk({tag, ".imm16"},  32'(id_imm16),  32'(ei[15:0]));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; flush = 1'b0;
    imem_rdata = 32'h0;

    //        rst stl red rpc           fl  rdata          addr          vld   instr                          pp4                         chkpp4
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'hDEAD_BEEF, 32'h0,        0, 32'h0,                          32'h0,                      1)); // 0 reset
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'hDEAD_BEEF, 32'h0,        0, 32'h0,                          32'h0,                      1)); // 1 reset
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h2008_0005, 32'h4,        1, 32'h2008_0005,                  32'h4,                      1)); // 2 first fetch
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'hA100_0001, 32'h8,        1, 32'hA100_0001,                  32'h8,                      1)); // 3
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'hA200_0002, 32'h8,        1, 32'hA100_0001,                  32'h8,                      1)); // 4 stall
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'hA200_0002, 32'h8,        1, 32'hA100_0001,                  32'h8,                      1)); // 5 stall
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'hA200_0002, 32'h8,        1, 32'hA100_0001,                  32'h8,                      1)); // 6 stall
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'hA200_0002, 32'hC,        1, 32'hA200_0002,                  32'hC,                      1)); // 7 release
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'hA300_0003, 32'h10,       1, 32'hA300_0003,                  32'h10,                     1)); // 8
    vecs.push_back(mk(0, 0, 1, 32'h100,      0, 32'hA400_0004, 32'h100,      BDS, BDS ? 32'hA400_0004 : 32'h0,  32'h14,                     BDS)); // 9 redirect @16
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'hB000_0000, 32'h104,      1, 32'hB000_0000,                  32'h104,                    1)); // 10
    vecs.push_back(mk(0, 1, 1, 32'h200,      0, 32'hB100_0001, 32'h200,      BDS, BDS ? 32'hB000_0000 : 32'h0,  32'h104,                    BDS)); // 11 redirect+stall
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'hC000_0000, 32'h204,      1, 32'hC000_0000,                  32'h204,                    1)); // 12
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hC100_0001, 32'h208,      0, 32'h0,                          32'h0,                      0)); // 13 flush
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'hC200_0002, 32'h208,      0, 32'h0,                          32'h0,                      0)); // 14 flush+stall
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'hC200_0002, 32'h20C,      1, 32'hC200_0002,                  32'h20C,                    1)); // 15
    vecs.push_back(mk(0, 0, 1, 32'h4000_0000,0, 32'hD000_0000, 32'h4000_0000, BDS, BDS ? 32'hD000_0000 : 32'h0, 32'h210,                    BDS)); // 16
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0800_0040, 32'h4000_0004, 1, 32'h0800_0040,                 32'h4000_0004,              1)); // 17 jump word
    vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFC,1, 32'hE000_0000, 32'hFFFF_FFFC, 0, 32'h0,                         32'h0,                      0)); // 18 flush+redirect
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'hE100_0001, 32'h0,        1, 32'hE100_0001,                  32'h0,                      1)); // 19 wrap
    vecs.push_back(mk(1, 1, 1, 32'h300,      0, 32'hE200_0002, 32'h0,        0, 32'h0,                          32'h0,                      1)); // 20 rst+stall+redirect
    vecs.push_back(mk(0, 0, 1, 32'h402,      0, 32'hF000_0000, 32'h402,      BDS, BDS ? 32'hF000_0000 : 32'h0,  32'h4,                      BDS)); // 21 unaligned redirect
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0123_4567, 32'h406,      1, 32'h0123_4567,                  32'h406,                    1)); // 22

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("v%0d", i);
      drive(vecs[i].rst, vecs[i].stall, vecs[i].redirect, vecs[i].rpc, vecs[i].flush, vecs[i].rdata);
      chk({tag, ".addr"},  imem_addr,       vecs[i].e_addr);
      chk({tag, ".valid"}, 32'(id_valid),   32'(vecs[i].e_vld));
      chk({tag, ".instr"}, id_instr,        vecs[i].e_instr);
      if (vecs[i].chk_pp4) chk({tag, ".pp4"}, id_pc_plus4, vecs[i].e_pp4);
      chk_fields(tag, vecs[i].e_instr);
      if (i == 2) begin
        chk("rel.rt",    32'(id_rt),    32'd8);
        chk("rel.imm16", 32'(id_imm16), 32'h0005);
        chk("rel.opc",   32'(id_opcode), 32'h08);
      end
      if (i == 17) chk("jtarget", id_jtarget, 32'h4000_0100);
    end

    // Hand sequence: after reset, free-running fetch walks 0,4,8,12 with pp4 one step behind
    drive(1, 0, 0, 32'h0, 0, 32'h0);
    chk("seq.rst_addr", imem_addr, 32'h0);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] w;
      w = 32'h1000_0000 + 32'(k);
      chk($sformatf("seq%0d.addr_pre", k), imem_addr, 32'(k * 4));
      drive(0, 0, 0, 32'h0, 0, w);
      chk($sformatf("seq%0d.pp4", k),   id_pc_plus4, 32'(k * 4 + 4));
      chk($sformatf("seq%0d.instr", k), id_instr,    w);
    end

    // Hand sequence: flush during a long stall, then stall alone keeps the bubble, release fetches
    drive(0, 1, 0, 32'h0, 1, 32'h7777_7777);
    chk("fs.addr",  imem_addr, 32'h10);
    chk("fs.valid", 32'(id_valid), 32'd0);
    drive(0, 1, 0, 32'h0, 0, 32'h7777_7777);
    chk("fs.hold_valid", 32'(id_valid), 32'd0);
    chk("fs.hold_instr", id_instr, 32'h0);
    drive(0, 0, 0, 32'h0, 0, 32'h7777_7777);
    chk("fs.rel_addr",  imem_addr, 32'h14);
    chk("fs.rel_instr", id_instr, 32'h7777_7777);
    chk("fs.rel_pp4",   id_pc_plus4, 32'h14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the MIPS32 core.
- Holds the PC and drives the instruction memory address.
- Latches the fetched word with its PC+4 and splits it into decode fields.
- imm16 feeds the 16-to-32 sign extender in ID; jump/branch redirects and hazard stalls are accepted from downstream.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble word (sll $0,$0,0) inserted on flush/reset.
- PC_W, 32, PC and address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  PC_W  current PC, equal to the PC register.
- imem_rdata  in  32  instruction at imem_addr, combinational read, valid the same cycle.
- stall  in  1  hazard hold: freeze PC and IF/ID.
- redirect  in  1  taken branch/jump resolved in ID.
- redirect_pc  in  PC_W  target for redirect.
- flush  in  1  kill IF/ID contents (exception/squash).
- id_valid  out  1  IF/ID holds a real instruction.
- id_instr  out  32  latched instruction.
- id_pc_plus4  out  PC_W  PC of latched instruction + 4.
- id_opcode  out  6  id_instr[31:26].
- id_rs  out  5  id_instr[25:21].
- id_rt  out  5  id_instr[20:16].
- id_rd  out  5  id_instr[15:11].
- id_shamt  out  5  id_instr[10:6].
- id_funct  out  6  id_instr[5:0].
- id_imm16  out  16  id_instr[15:0], to sign extender.
- id_jtarget  out  PC_W  {id_pc_plus4[31:28], id_instr[25:0], 2'b00}.

Behaviour:
- Reset (rst=1 at clk edge): pc<=RESET_PC, id_instr<=NOP_INSTR, id_pc_plus4<=0, id_valid<=0. rst overrides all other inputs.
- Decode fields are purely combinational slices of id_instr; zero added latency.
- Fetch-to-ID latency is 1 cycle: word at PC in cycle N appears on id_instr in cycle N+1.
- PC next-state priority, highest first:
  - rst: RESET_PC.
  - redirect: redirect_pc. Overrides stall, so the redirect is never lost.
  - stall: hold.
  - otherwise: pc+4, wrapping modulo 2^PC_W (32'hFFFF_FFFC -> 0).
- IF/ID next-state priority, highest first:
  - rst.
  - flush: NOP_INSTR, id_valid=0.
  - redirect: handled per the macro below.
  - stall: hold id_instr, id_pc_plus4 and id_valid unchanged.
  - otherwise: capture imem_rdata, pc+4, id_valid=1.
- flush with stall: flush wins (bubble inserted). PC still obeys its own priority.
- flush with redirect: PC takes redirect_pc and IF/ID becomes a bubble.
- No alignment checking; PC[1:0] are carried through unchanged from redirect_pc.

Optional Feature:
- BRANCH_DELAY_SLOT_EN defined:
  - On redirect (no flush, no rst), IF/ID captures imem_rdata/pc+4 with id_valid=1, so the delay-slot instruction executes. MIPS architectural semantics.
  - If stall and redirect coincide, IF/ID holds, but the PC still takes redirect_pc.
- Undefined:
  - On redirect, IF/ID loads NOP_INSTR with id_valid=0, so the wrong-path instruction is squashed.

Decomposition:
- Shared package/header mips_pkg:
  - MIPS_NOP constant.
  - Field bit-position constants (OPC_HI/LO, RS_HI/LO, RT, RD, SHAMT, FUNCT, IMM).
  - PC_W default and RESET_PC default.
- Sub-module: none required.
- The pc register and IF/ID register may be split as pc_reg (PC with next-PC mux) if the core reuses it. Otherwise keep it a single module.

Test Plan:
- Reset: rst=1 for 2 cycles, then release with imem returning 32'h2008_0005 -> imem_addr=0; one cycle later id_instr=32'h2008_0005, id_pc_plus4=4, id_valid=1, id_rt=8, id_imm16=16'h0005.
- Sequential fetch: 4 cycles with no stall -> imem_addr sequence 0,4,8,12; id_pc_plus4 lags by one cycle (4,8,12).
- Stall: stall=1 at PC=8 for 3 cycles -> imem_addr stays 8 and id_instr/id_valid unchanged; after release, PC=12 next cycle.
- Redirect with stall: redirect=1, redirect_pc=32'h0000_0100 at PC=16 -> next imem_addr=32'h100. Without the macro, id_valid=0 and id_instr=0. With the macro, id_instr=word@16 and id_pc_plus4=20. Repeat with stall=1 simultaneously -> PC still 32'h100.
- Flush and jtarget: flush=1 -> id_valid=0, id_instr=NOP next cycle. Separately, latch 32'h0800_0040 at PC=32'h4000_0000 -> id_jtarget=32'h4000_0100.
- Wrap and mid-operation reset: PC=32'hFFFF_FFFC advances to 0. Asserting rst during stall+redirect -> PC=RESET_PC, id_valid=0.
